// File: rtl/watch_pkg.sv
// Shared definitions for the watch key handling: press-FSM states and
// conversion of millisecond timing parameters into clock-cycle counts.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_DONE = 2'd2
    } key_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return ms * (clk_hz / 1000);
    endfunction

    // Width of a counter that must hold 0..n without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debouncer for one active-low raw key.
// level toggles only after the synchronized sample has disagreed for DEB cycles.
module key_debounce
    import watch_pkg::*;
#(
    parameter int unsigned IN_CLK_HZ   = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level
);

    localparam int unsigned DEB = ms_to_cycles(IN_CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned CW  = cnt_width(DEB);
    localparam logic [CW-1:0] DEB_C = CW'(DEB);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] deb_cnt;

    // stage p0/p1: metastability filter on the inverted (active-high) key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= ~key_n;
            sync_p1 <= sync_p0;
        end
    end

    // stage p2: the counter never exceeds DEB, so it cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else if (sync_p1 == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_C) begin
            deb_cnt <= '0;
            level   <= ~level;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_events.sv
// Two-key front end: debounced levels, short/long press events per key and
// a long press of both keys together. Overlapping presses taint each other.
module key_events
    import watch_pkg::*;
#(
    parameter int unsigned IN_CLK_HZ   = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 4000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_one_n,
    input  logic key_two_n,
    output logic one_held,
    output logic two_held,
    output logic short_one,
    output logic short_two,
    output logic long_one,
    output logic long_two,
    output logic long_both
);

    localparam int unsigned LONG = ms_to_cycles(IN_CLK_HZ, LONG_MS);
    localparam int unsigned LW   = cnt_width(LONG);
    localparam logic [LW-1:0] LONG_C = LW'(LONG);

    logic [1:0]    lvl;
    logic [1:0]    other_lvl;
    logic [1:0]    tainted;
    key_state_t    state    [2];
    key_state_t    state_nx [2];
    logic [LW-1:0] hold_cnt    [2];
    logic [LW-1:0] hold_cnt_nx [2];
    logic [1:0]    taint;
    logic [1:0]    taint_nx;
    logic [1:0]    short_nx;
    logic [1:0]    long_nx;
    logic [1:0]    short_q;
    logic [1:0]    long_q;

    logic          both_lvl;
    logic          both_idle;
    logic [LW-1:0] combo_cnt;
    logic [LW-1:0] combo_cnt_nx;
    logic          combo_fire;
    logic          combo_done;
    logic          combo_done_nx;
    logic          long_both_q;

    key_debounce #(
        .IN_CLK_HZ  (IN_CLK_HZ),
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_deb_one (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_one_n),
        .level(lvl[0])
    );

    key_debounce #(
        .IN_CLK_HZ  (IN_CLK_HZ),
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_deb_two (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_two_n),
        .level(lvl[1])
    );

    assign other_lvl = {lvl[0], lvl[1]};
    // The other key being down right now counts as taint even before the flag is set.
    assign tainted   = taint | other_lvl;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            state_nx[k]    = state[k];
            hold_cnt_nx[k] = hold_cnt[k];
            short_nx[k]    = 1'b0;
            long_nx[k]     = 1'b0;
            case (state[k])
                IDLE: begin
                    hold_cnt_nx[k] = '0;
                    if (lvl[k]) state_nx[k] = PRESSED;
                end
                PRESSED: begin
                    if (!lvl[k]) begin
                        state_nx[k] = IDLE;
                        short_nx[k] = ~tainted[k];
                    end else if (hold_cnt[k] == LONG_C) begin
                        state_nx[k] = LONG_DONE;
                        long_nx[k]  = ~tainted[k];
                    end else begin
                        hold_cnt_nx[k] = hold_cnt[k] + 1'b1;
                    end
                end
                LONG_DONE: begin
                    if (!lvl[k]) state_nx[k] = IDLE;
                end
                default: state_nx[k] = IDLE;
            endcase
            if (state_nx[k] == IDLE) begin
                taint_nx[k] = 1'b0;
            end else begin
                taint_nx[k] = taint[k] | other_lvl[k];
            end
        end
    end

    assign both_lvl  = &lvl;
    assign both_idle = (state[0] == IDLE) && (state[1] == IDLE);

    always_comb begin
        combo_cnt_nx = combo_cnt;
        if (!both_lvl) begin
            combo_cnt_nx = '0;
        end else if (combo_cnt != LONG_C) begin
            combo_cnt_nx = combo_cnt + 1'b1;
        end
        combo_fire    = both_lvl && (combo_cnt != LONG_C) && (combo_cnt_nx == LONG_C)
                        && !combo_done;
        combo_done_nx = combo_done;
        if (combo_fire) begin
            combo_done_nx = 1'b1;
        end else if (both_idle) begin
            combo_done_nx = 1'b0;
        end
    end

    // stage p3: press FSMs, combo tracking and registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                state[k]    <= IDLE;
                hold_cnt[k] <= '0;
            end
            taint       <= '0;
            short_q     <= '0;
            long_q      <= '0;
            combo_cnt   <= '0;
            combo_done  <= 1'b0;
            long_both_q <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                state[k]    <= state_nx[k];
                hold_cnt[k] <= hold_cnt_nx[k];
            end
            taint       <= taint_nx;
            short_q     <= short_nx;
            long_q      <= long_nx;
            combo_cnt   <= combo_cnt_nx;
            combo_done  <= combo_done_nx;
            long_both_q <= combo_fire;
        end
    end

    assign one_held  = lvl[0];
    assign two_held  = lvl[1];
    assign short_one = short_q[0];
    assign short_two = short_q[1];
    assign long_one  = long_q[0];
    assign long_two  = long_q[1];
    assign long_both = long_both_q;

endmodule

// File: tb/tb_key_events.sv
// Randomized and scenario bench for key_events against a press-level
// reference model (sampled levels, run lengths, press records).
module tb_key_events;

    localparam int DEB  = 5;
    localparam int LONG = 50;

    logic clk = 1'b0;
    logic rst_n;
    logic key_one_n;
    logic key_two_n;
    logic one_held, two_held, short_one, short_two, long_one, long_two, long_both;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    key_events #(
        .IN_CLK_HZ  (1000),
        .DEBOUNCE_MS(5),
        .LONG_MS    (50)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_one_n(key_one_n),
        .key_two_n(key_two_n),
        .one_held (one_held),
        .two_held (two_held),
        .short_one(short_one),
        .short_two(short_two),
        .long_one (long_one),
        .long_two (long_two),
        .long_both(long_both)
    );

    // Reference model state: raw-sample delay line, disagreement run lengths,
    // accepted levels and per-press bookkeeping.
    typedef struct packed {
        logic [1:0]       d1, d2, lvl, inpress, tnt, ldone, sht, lng;
        logic             lboth, cused;
        logic [1:0][31:0] run, hold;
        logic [31:0]      brun;
    } m_t;

    m_t m;

    function automatic m_t step(m_t c, logic k1n, logic k2n);
        m_t n;
        logic [1:0] pr;
        logic oth, both;
        n = c;
        pr = ~{k2n, k1n};
        n.sht = '0;
        n.lng = '0;
        n.lboth = 1'b0;
        for (int k = 0; k < 2; k++) begin
            oth = c.lvl[1-k];
            n.d1[k] = pr[k];
            n.d2[k] = c.d1[k];
            if (c.d2[k] != c.lvl[k]) begin
                n.run[k] = c.run[k] + 1;
                if (n.run[k] == DEB + 1) begin
                    n.lvl[k] = ~c.lvl[k];
                    n.run[k] = 0;
                end
            end else begin
                n.run[k] = 0;
            end
            if (!c.inpress[k]) begin
                if (c.lvl[k]) begin
                    n.inpress[k] = 1'b1;
                    n.hold[k]    = 0;
                    n.tnt[k]     = oth;
                    n.ldone[k]   = 1'b0;
                end
            end else if (!c.lvl[k]) begin
                n.inpress[k] = 1'b0;
                n.sht[k] = !c.ldone[k] && !(c.tnt[k] || oth);
                n.tnt[k] = 1'b0;
            end else begin
                n.hold[k] = c.hold[k] + 1;
                n.tnt[k]  = c.tnt[k] | oth;
                if (n.hold[k] == LONG + 1 && !c.ldone[k]) begin
                    n.ldone[k] = 1'b1;
                    n.lng[k]   = !(c.tnt[k] || oth);
                end
            end
        end
        both = c.lvl[0] & c.lvl[1];
        n.brun  = both ? c.brun + 1 : 0;
        n.lboth = both && (n.brun == LONG) && !c.cused;
        if (n.lboth) n.cused = 1'b1;
        else if (!c.inpress[0] && !c.inpress[1]) n.cused = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, key_one_n, key_two_n);
    end

    logic [6:0] obs, want;
    assign obs  = {one_held, two_held, short_one, short_two, long_one, long_two, long_both};
    assign want = {m.lvl[0], m.lvl[1], m.sht[0], m.sht[1], m.lng[0], m.lng[1], m.lboth};

    task automatic idle(input int n);
        key_one_n = 1'b1;
        key_two_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_one_n = 1'($urandom);
            key_two_n = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b want=0000000", i, obs);
            end
        end
        key_one_n = 1'b1;
        key_two_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            key_one_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL reset_press cyc=%0d got=%b want=%b", i, obs, want);
            end
        end
        n_checks++;
        if (one_held !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_held got=%b want=1", one_held);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%b want=0000000", obs);
        end
        @(negedge clk);
        key_one_n = 1'b1;
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_short_press();
        int rise_at, n_short, n_other;
        rise_at = -1;
        n_short = 0;
        n_other = 0;
        for (int i = 0; i < 45; i++) begin
            key_one_n = (i < 20) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL short_model cyc=%0d got=%b want=%b", i, obs, want);
            end
            if (one_held && rise_at < 0) rise_at = i + 1;
            n_short += int'(short_one);
            n_other += int'(short_two) + int'(long_one) + int'(long_two) + int'(long_both);
        end
        n_checks++;
        if (rise_at != 2 + DEB + 1) begin
            n_fail++;
            $display("FAIL short_rise_latency got=%0d want=%0d", rise_at, 2 + DEB + 1);
        end
        n_checks++;
        if (n_short != 1 || n_other != 0) begin
            n_fail++;
            $display("FAIL short_counts got short=%0d other=%0d want short=1 other=0",
                     n_short, n_other);
        end
        idle(5);
    endtask

    task automatic test_bounce();
        int n_held, n_evt;
        n_held = 0;
        n_evt = 0;
        for (int i = 0; i < 45; i++) begin
            key_one_n = (i < 30 && (i % 6) < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL bounce_model cyc=%0d got=%b want=%b", i, obs, want);
            end
            n_held += int'(one_held);
            n_evt  += int'(short_one) + int'(long_one) + int'(long_both);
        end
        n_checks++;
        if (n_held != 0 || n_evt != 0) begin
            n_fail++;
            $display("FAIL bounce_counts got held=%0d events=%0d want 0 0", n_held, n_evt);
        end
    endtask

    task automatic test_long_press();
        int rise_at, long_at, n_long, n_other;
        rise_at = -1;
        long_at = -1;
        n_long = 0;
        n_other = 0;
        for (int i = 0; i < 100; i++) begin
            key_two_n = (i < 80) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL long_model cyc=%0d got=%b want=%b", i, obs, want);
            end
            if (two_held && rise_at < 0) rise_at = i;
            if (long_two) long_at = i;
            n_long  += int'(long_two);
            n_other += int'(short_two) + int'(short_one) + int'(long_one) + int'(long_both);
        end
        n_checks++;
        if (n_long != 1 || n_other != 0) begin
            n_fail++;
            $display("FAIL long_counts got long=%0d other=%0d want long=1 other=0",
                     n_long, n_other);
        end
        n_checks++;
        if (long_at - rise_at < LONG || long_at - rise_at > LONG + 3) begin
            n_fail++;
            $display("FAIL long_delay got=%0d want %0d..%0d", long_at - rise_at, LONG, LONG + 3);
        end
        idle(5);
    endtask

    task automatic test_combo();
        int n_both, n_key;
        n_both = 0;
        n_key = 0;
        for (int i = 0; i < 100; i++) begin
            key_one_n = (i < 80) ? 1'b0 : 1'b1;
            key_two_n = (i >= 3 && i < 83) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL combo_model cyc=%0d got=%b want=%b", i, obs, want);
            end
            n_both += int'(long_both);
            n_key  += int'(short_one) + int'(short_two) + int'(long_one) + int'(long_two);
        end
        n_checks++;
        if (n_both != 1 || n_key != 0) begin
            n_fail++;
            $display("FAIL combo_counts got both=%0d key=%0d want both=1 key=0", n_both, n_key);
        end
        idle(5);
    endtask

    task automatic test_taint_tap();
        int n_short, seen_one, seen_two;
        n_short = 0;
        seen_one = 0;
        seen_two = 0;
        for (int i = 0; i < 45; i++) begin
            key_one_n = (i < 20) ? 1'b0 : 1'b1;
            key_two_n = (i >= 5 && i < 15) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL taint_model cyc=%0d got=%b want=%b", i, obs, want);
            end
            n_short  += int'(short_one) + int'(short_two);
            seen_one |= int'(one_held);
            seen_two |= int'(two_held);
        end
        n_checks++;
        if (n_short != 0 || seen_one != 1 || seen_two != 1) begin
            n_fail++;
            $display("FAIL taint_counts got short=%0d held1=%0d held2=%0d want 0 1 1",
                     n_short, seen_one, seen_two);
        end
    endtask

    task automatic test_reset_mid_press();
        int n_long;
        n_long = 0;
        for (int i = 0; i < 80; i++) begin
            key_one_n = (i < 60) ? 1'b0 : 1'b1;
            rst_n     = (i >= 30 && i < 33) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL midrst_model cyc=%0d got=%b want=%b", i, obs, want);
            end
            if (!rst_n) begin
                n_checks++;
                if (obs !== 7'b0) begin
                    n_fail++;
                    $display("FAIL midrst_zero cyc=%0d got=%b want=0000000", i, obs);
                end
            end
            n_long += int'(long_one);
        end
        n_checks++;
        if (n_long != 0) begin
            n_fail++;
            $display("FAIL midrst_long got=%0d want=0", n_long);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r1, r2, rcnt;
        r1 = 1;
        r2 = 1;
        rcnt = 0;
        for (int i = 0; i < 2000; i++) begin
            if (--r1 == 0) begin
                key_one_n = ~key_one_n;
                r1 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 70);
            end
            if (--r2 == 0) begin
                key_two_n = ~key_two_n;
                r2 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 70);
            end
            if (rcnt > 0) rcnt--;
            else if ($urandom_range(0, 499) == 0) rcnt = 2;
            rst_n = (rcnt > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", i, obs, want);
            end
        end
        rst_n = 1'b1;
        idle(10);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        key_one_n = 1'b1;
        key_two_n = 1'b1;
        test_reset();
        test_short_press();
        test_bounce();
        test_long_press();
        test_combo();
        test_taint_tap();
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
